// File: rtl/fdtd_ez_sweep_ctrl.sv
// Sweep sequencer for the pipelined FDTD Ez update. It reads Hy/Ez for cells 0..NX-1,
// follows each index through the read and datapath latency, and issues the Ez write-backs.
module fdtd_ez_sweep_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int RD_LAT   = 1,
  parameter int PIPE_LAT = 6,
  parameter int SWEEP_W  = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [ADDR_W:0]    nx_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               hy_rd_en_o,
  output logic [ADDR_W-1:0]  hy_rd_addr_o,
  output logic               ez_rd_en_o,
  output logic [ADDR_W-1:0]  ez_rd_addr_o,
  output logic               calc_clken_o,
  output logic               ez_wr_en_o,
  output logic [ADDR_W-1:0]  ez_wr_addr_o,
  output logic [SWEEP_W-1:0] sweep_cnt_o
);

  localparam int DLY = RD_LAT + PIPE_LAT;
  localparam logic [ADDR_W:0] MAX_NX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] NX_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] NX_TWO = (ADDR_W + 1)'(2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W:0]   nx_q;
  logic [ADDR_W:0]   nx_eff;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              last_rd;
  logic              wr_cand;
  logic              flush;
  logic              pending;
  logic [RD_LAT-1:0] clken_line;
  logic [DLY-1:0]    vld_line;
  logic [ADDR_W-1:0] addr_line [DLY];

  // Pending means something is still in flight after the entry now leaving the last stage.
  always_comb begin
    nx_eff  = (nx_i > MAX_NX) ? MAX_NX : nx_i;
    last_rd = ({1'b0, rd_addr} == (nx_q - NX_ONE));
    wr_cand = rd_en && (rd_addr != '0);
    flush   = abort_i && ((state == RUN) || (state == DRAIN));
    pending = |vld_line[DLY-2:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      nx_q        <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      sweep_cnt_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !abort_i) begin
            nx_q    <= nx_eff;
            busy_o  <= 1'b1;
            rd_addr <= '0;
            if (nx_eff >= NX_TWO) begin
              state <= RUN;
              rd_en <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        RUN: begin
          if (abort_i) begin
            state  <= IDLE;
            rd_en  <= 1'b0;
            busy_o <= 1'b0;
          end else if (last_rd) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (abort_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (!pending) begin
            state       <= DONE;
            done_o      <= 1'b1;
            sweep_cnt_o <= sweep_cnt_o + SWEEP_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Addresses only advance alongside a valid entry, so the write address holds between writes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clken_line <= '0;
      vld_line   <= '0;
      for (int i = 0; i < DLY; i++) addr_line[i] <= '0;
    end else if (flush) begin
      clken_line <= '0;
      vld_line   <= '0;
    end else begin
      clken_line[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) clken_line[i] <= clken_line[i-1];
      vld_line[0] <= wr_cand;
      if (wr_cand) addr_line[0] <= rd_addr;
      for (int i = 1; i < DLY; i++) begin
        vld_line[i] <= vld_line[i-1];
        if (vld_line[i-1]) addr_line[i] <= addr_line[i-1];
      end
    end
  end

  assign hy_rd_en_o   = rd_en;
  assign hy_rd_addr_o = rd_addr;
  assign ez_rd_en_o   = rd_en;
  assign ez_rd_addr_o = rd_addr;
  assign calc_clken_o = clken_line[RD_LAT-1];
  assign ez_wr_en_o   = vld_line[DLY-1];
  assign ez_wr_addr_o = addr_line[DLY-1];

endmodule

// File: tb/tb_fdtd_ez_sweep_ctrl.sv
// Scoreboard bench for fdtd_ez_sweep_ctrl: directed sweeps push expected strobes with
// their cycle numbers, and a negedge monitor pops and compares whatever the DUT emits.
module tb_fdtd_ez_sweep_ctrl;

  localparam int ADDR_W   = 10;
  localparam int RD_LAT   = 1;
  localparam int PIPE_LAT = 6;
  localparam int SWEEP_W  = 16;
  localparam int DLY      = RD_LAT + PIPE_LAT;
  localparam int NO_CUT   = 32'h7fff_ffff;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic               CLK;
  logic               RST_N;
  logic               start_i;
  logic               abort_i;
  logic [ADDR_W:0]    nx_i;
  logic               busy_o;
  logic               done_o;
  logic               hy_rd_en_o;
  logic [ADDR_W-1:0]  hy_rd_addr_o;
  logic               ez_rd_en_o;
  logic [ADDR_W-1:0]  ez_rd_addr_o;
  logic               calc_clken_o;
  logic               ez_wr_en_o;
  logic [ADDR_W-1:0]  ez_wr_addr_o;
  logic [SWEEP_W-1:0] sweep_cnt_o;

  int   cyc;
  int   checks;
  int   errors;
  int   exp_cnt;
  int   c0;
  exp_t rd_q[$];
  exp_t ck_q[$];
  exp_t wr_q[$];
  exp_t dn_q[$];

  fdtd_ez_sweep_ctrl #(
    .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .PIPE_LAT(PIPE_LAT), .SWEEP_W(SWEEP_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .start_i(start_i), .abort_i(abort_i), .nx_i(nx_i),
    .busy_o(busy_o), .done_o(done_o),
    .hy_rd_en_o(hy_rd_en_o), .hy_rd_addr_o(hy_rd_addr_o),
    .ez_rd_en_o(ez_rd_en_o), .ez_rd_addr_o(ez_rd_addr_o),
    .calc_clken_o(calc_clken_o), .ez_wr_en_o(ez_wr_en_o), .ez_wr_addr_o(ez_wr_addr_o),
    .sweep_cnt_o(sweep_cnt_o)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc++;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic flag_fail(input string name, input logic [63:0] actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0d, expected no strobe (cycle %0d)", name, actual, cyc);
  endtask

  // Strobes in cycles later than cut are never seen (abort or reset intervenes first).
  task automatic expect_sweep(input int start_cyc, input int nx, input int cut);
    int   n;
    exp_t e;
    n = (nx > (1 << ADDR_W)) ? (1 << ADDR_W) : nx;
    if (n >= 2) begin
      for (int k = 0; k < n; k++) begin
        e.cyc = start_cyc + 1 + k;
        e.val = k;
        if (e.cyc <= cut) rd_q.push_back(e);
        e.cyc = start_cyc + 1 + k + RD_LAT;
        e.val = 1;
        if (e.cyc <= cut) ck_q.push_back(e);
        if (k >= 1) begin
          e.cyc = start_cyc + 1 + k + DLY;
          e.val = k;
          if (e.cyc <= cut) wr_q.push_back(e);
        end
      end
    end
    e.cyc = (n < 2) ? start_cyc + 2 : start_cyc + n + DLY + 1;
    if (e.cyc <= cut) begin
      exp_cnt++;
      e.val = exp_cnt;
      dn_q.push_back(e);
    end
  endtask

  task automatic run_until(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic apply_stimulus(input int nx, input logic ab);
    start_i = 1'b1;
    abort_i = ab;
    nx_i    = (ADDR_W + 1)'(nx);
    @(posedge CLK);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (hy_rd_en_o) begin
      if (rd_q.size() == 0) flag_fail("rd_unexpected", hy_rd_addr_o);
      else begin
        e = rd_q.pop_front();
        check_output("rd_cycle", cyc, e.cyc);
        check_output("hy_rd_addr", hy_rd_addr_o, e.val);
        check_output("ez_rd_en", ez_rd_en_o, 1);
        check_output("ez_rd_addr", ez_rd_addr_o, e.val);
      end
    end else if (ez_rd_en_o) flag_fail("ez_rd_en_alone", ez_rd_addr_o);
    if (calc_clken_o) begin
      if (ck_q.size() == 0) flag_fail("clken_unexpected", 1);
      else begin
        e = ck_q.pop_front();
        check_output("clken_cycle", cyc, e.cyc);
      end
    end
    if (ez_wr_en_o) begin
      if (wr_q.size() == 0) flag_fail("wr_unexpected", ez_wr_addr_o);
      else begin
        e = wr_q.pop_front();
        check_output("wr_cycle", cyc, e.cyc);
        check_output("ez_wr_addr", ez_wr_addr_o, e.val);
      end
    end
    if (done_o) begin
      if (dn_q.size() == 0) flag_fail("done_unexpected", sweep_cnt_o);
      else begin
        e = dn_q.pop_front();
        check_output("done_cycle", cyc, e.cyc);
        check_output("sweep_cnt_at_done", sweep_cnt_o, e.val);
        check_output("busy_at_done", busy_o, 1);
      end
    end
  end

  initial begin
    cyc     = 0;
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    RST_N   = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    nx_i    = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_output("reset_busy", busy_o, 0);
    check_output("reset_done", done_o, 0);
    check_output("reset_rd_en", hy_rd_en_o, 0);
    check_output("reset_rd_addr", hy_rd_addr_o, 0);
    check_output("reset_clken", calc_clken_o, 0);
    check_output("reset_wr_en", ez_wr_en_o, 0);
    check_output("reset_wr_addr", ez_wr_addr_o, 0);
    check_output("reset_sweep_cnt", sweep_cnt_o, 0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    $display("[TB] NX=4 basic sweep");
    c0 = cyc;
    expect_sweep(c0, 4, NO_CUT);
    apply_stimulus(4, 1'b0);
    check_output("busy_first_run", busy_o, 1);
    run_until(c0 + 14);
    check_output("busy_after_nx4", busy_o, 0);
    check_output("wr_addr_hold_nx4", ez_wr_addr_o, 3);

    $display("[TB] NX=1 and NX=0 degenerate sweeps");
    c0 = cyc;
    expect_sweep(c0, 1, NO_CUT);
    apply_stimulus(1, 1'b0);
    check_output("busy_nx1_c1", busy_o, 1);
    run_until(c0 + 2);
    check_output("busy_nx1_c2", busy_o, 1);
    run_until(c0 + 3);
    check_output("busy_nx1_c3", busy_o, 0);
    c0 = cyc;
    expect_sweep(c0, 0, NO_CUT);
    apply_stimulus(0, 1'b0);
    run_until(c0 + 5);

    $display("[TB] start with abort in IDLE");
    apply_stimulus(5, 1'b1);
    check_output("busy_start_abort", busy_o, 0);
    run_until(cyc + 4);

    $display("[TB] NX=8 aborted in cycle 3, then NX=2");
    c0 = cyc;
    expect_sweep(c0, 8, c0 + 3);
    apply_stimulus(8, 1'b0);
    run_until(c0 + 3);
    abort_i = 1'b1;
    @(posedge CLK);
    #1;
    abort_i = 1'b0;
    check_output("busy_after_abort", busy_o, 0);
    run_until(c0 + 20);
    check_output("sweep_cnt_after_abort", sweep_cnt_o, exp_cnt);
    c0 = cyc;
    expect_sweep(c0, 2, NO_CUT);
    apply_stimulus(2, 1'b0);
    run_until(c0 + 12);

    $display("[TB] start pulses during RUN and in the done cycle");
    c0 = cyc;
    expect_sweep(c0, 3, NO_CUT);
    apply_stimulus(3, 1'b0);
    run_until(c0 + 2);
    start_i = 1'b1;
    nx_i    = 11'd5;
    @(posedge CLK);
    #1;
    start_i = 1'b0;
    run_until(c0 + 3 + DLY + 1);
    start_i = 1'b1;
    @(posedge CLK);
    #1;
    start_i = 1'b0;
    run_until(c0 + 30);
    check_output("busy_after_ignored_starts", busy_o, 0);

    $display("[TB] reset asserted during DRAIN");
    c0 = cyc;
    expect_sweep(c0, 4, c0 + 5);
    apply_stimulus(4, 1'b0);
    run_until(c0 + 6);
    RST_N = 1'b0;
    #1;
    exp_cnt = 0;
    check_output("rst_drain_busy", busy_o, 0);
    check_output("rst_drain_rd_en", hy_rd_en_o, 0);
    check_output("rst_drain_clken", calc_clken_o, 0);
    check_output("rst_drain_wr_en", ez_wr_en_o, 0);
    check_output("rst_drain_sweep_cnt", sweep_cnt_o, 0);
    run_until(c0 + 8);
    RST_N = 1'b1;
    run_until(c0 + 25);
    check_output("busy_after_reset", busy_o, 0);

    $display("[TB] NX=1024 full sweep and NX=2047 clamp");
    c0 = cyc;
    expect_sweep(c0, 1024, NO_CUT);
    apply_stimulus(1024, 1'b0);
    run_until(c0 + 1024 + DLY + 4);
    check_output("wr_addr_hold_1024", ez_wr_addr_o, 1023);
    c0 = cyc;
    expect_sweep(c0, 2047, NO_CUT);
    apply_stimulus(2047, 1'b0);
    run_until(c0 + 1024 + DLY + 4);
    check_output("busy_after_clamp", busy_o, 0);

    check_output("rd_q_left", rd_q.size(), 0);
    check_output("ck_q_left", ck_q.size(), 0);
    check_output("wr_q_left", wr_q.size(), 0);
    check_output("dn_q_left", dn_q.size(), 0);
    check_output("final_sweep_cnt", sweep_cnt_o, exp_cnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
